uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 147 ++++++++++++++
 tb/tb_uart_tx_arb.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: 4-way round-robin message arbiter in front of a UART TX FIFO.
// Define UART_ARB_TIMEOUT_EN to force release of an owner that stops sending.
module uart_tx_arb #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic [3:0]  REQ,
    input  logic [3:0]  LAST,
    input  logic [31:0] DATA,
    input  logic        TXFIFO_FULL,
    output logic [3:0]  ACK,
    output logic [3:0]  GNT,
    output logic        WR_TX,
    output logic [7:0]  WRDATA,
    output logic        BUSY,
    output logic        TIMEOUT_IRQ
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_gnt;
    logic [3:0] w_gnt_nxt;
    logic [1:0] r_ptr;
    logic [1:0] w_ptr_nxt;
    logic [1:0] r_own;
    logic [1:0] w_own_nxt;

    logic [1:0] w_sel;
    logic [1:0] w_idx;
    logic       w_found;
    logic       w_req_own;
    logic       w_last_own;
    logic [7:0] w_lane;
    logic       w_wr;
    logic       w_to;

    // First requester at or after the pointer, wrapping 3 -> 0.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        w_idx   = r_ptr;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && REQ[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_req_own  = REQ[r_own];
    assign w_last_own = LAST[r_own];
    assign w_lane     = DATA[{r_own, 3'b000} +: 8];

    assign w_wr = (r_state == SEND) && w_req_own && EN
                  && !TXFIFO_FULL && !RST;

    assign WR_TX  = w_wr;
    assign ACK    = w_wr ? r_gnt : 4'b0000;
    assign WRDATA = w_wr ? w_lane : 8'h00;
    assign GNT    = r_gnt;
    assign BUSY   = (r_state == SEND);

`ifdef UART_ARB_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       r_irq;

    // Counts only cycles where the owner is enabled but has nothing to send.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_to      = 1'b0;
        if (r_state == IDLE) begin
            w_cnt_nxt = 8'd0;
        end else if (w_wr || TXFIFO_FULL) begin
            w_cnt_nxt = 8'd0;
        end else if (!w_req_own && EN) begin
            if (r_cnt == 8'(TIMEOUT_CYC - 1)) begin
                w_to      = 1'b1;
                w_cnt_nxt = 8'd0;
            end else begin
                w_cnt_nxt = r_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= 8'd0;
            r_irq <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_irq <= w_to;
        end
    end

    assign TIMEOUT_IRQ = r_irq;
`else
    assign w_to        = 1'b0;
    assign TIMEOUT_IRQ = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        w_own_nxt   = r_own;
        unique case (r_state)
            IDLE: begin
                if (EN && w_found) begin
                    w_state_nxt = SEND;
                    w_gnt_nxt   = 4'b0001 << w_sel;
                    w_own_nxt   = w_sel;
                end
            end
            SEND: begin
                if ((w_wr && w_last_own) || w_to) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = 4'b0000;
                    w_ptr_nxt   = r_own + 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_gnt   <= 4'b0000;
            r_ptr   <= 2'd0;
            r_own   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_own   <= w_own_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed scenarios with literal checks plus a
// message-level reference model compared on every falling edge.
module tb_uart_tx_arb;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TCYC = 8;
`else
    localparam int TCYC = 255;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic [3:0]  REQ;
    logic [3:0]  LAST;
    logic [31:0] DATA;
    logic        TXFIFO_FULL;
    logic [3:0]  ACK;
    logic [3:0]  GNT;
    logic        WR_TX;
    logic [7:0]  WRDATA;
    logic        BUSY;
    logic        TIMEOUT_IRQ;

    int total = 0;
    int bad   = 0;

    uart_tx_arb #(.TIMEOUT_CYC(TCYC)) dut (
        .CLK(CLK),
        .RST(RST),
        .EN(EN),
        .REQ(REQ),
        .LAST(LAST),
        .DATA(DATA),
        .TXFIFO_FULL(TXFIFO_FULL),
        .ACK(ACK),
        .GNT(GNT),
        .WR_TX(WR_TX),
        .WRDATA(WRDATA),
        .BUSY(BUSY),
        .TIMEOUT_IRQ(TIMEOUT_IRQ)
    );

    always #5 CLK = ~CLK;

    // Reference model: owner index (-1 when idle), search pointer,
    // idle-owner counter and pending interrupt.
    int m_own = -1;
    int m_ptr = 0;
    int m_cnt = 0;
    bit m_irq = 1'b0;

    always @(negedge CLK) begin
        logic       wr;
        logic [3:0] eg;
        logic [3:0] ea;
        logic [7:0] ed;
        logic       eb;
        eg = 4'b0000;
        ea = 4'b0000;
        ed = 8'h00;
        wr = 1'b0;
        eb = (m_own >= 0);
        if (m_own >= 0) begin
            eg = 4'(1 << m_own);
            wr = !RST && REQ[m_own] && EN && !TXFIFO_FULL;
            if (wr) begin
                ea = eg;
                ed = DATA[m_own*8 +: 8];
            end
        end
        total++;
        if ({GNT, BUSY, WR_TX, ACK, WRDATA, TIMEOUT_IRQ} !==
            {eg, eb, wr, ea, ed, m_irq}) begin
            bad++;
            $display("FAIL model t=%0t got gnt=%b busy=%b wr=%b ack=%b d=%h irq=%b want gnt=%b busy=%b wr=%b ack=%b d=%h irq=%b",
                     $time, GNT, BUSY, WR_TX, ACK, WRDATA, TIMEOUT_IRQ,
                     eg, eb, wr, ea, ed, m_irq);
        end
        if (RST) begin
            m_own = -1;
            m_ptr = 0;
            m_cnt = 0;
            m_irq = 1'b0;
        end else begin
            m_irq = 1'b0;
            if (m_own < 0) begin
                if (EN && REQ != 4'b0000) begin
                    for (int k = 0; k < 4; k++)
                        if (m_own < 0 && REQ[(m_ptr + k) % 4])
                            m_own = (m_ptr + k) % 4;
                    m_cnt = 0;
                end
            end else if (wr) begin
                m_cnt = 0;
                if (LAST[m_own]) begin
                    m_ptr = (m_own + 1) % 4;
                    m_own = -1;
                end
            end else begin
`ifdef UART_ARB_TIMEOUT_EN
                if (TXFIFO_FULL) begin
                    m_cnt = 0;
                end else if (!REQ[m_own] && EN) begin
                    m_cnt++;
                    if (m_cnt == TCYC) begin
                        m_irq = 1'b1;
                        m_ptr = (m_own + 1) % 4;
                        m_own = -1;
                        m_cnt = 0;
                    end
                end
`endif
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic look();
        @(negedge CLK);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    int         n;
    int         wcyc [8];
    logic [7:0] wdat [8];
    logic [3:0] wg   [8];
    logic [3:0] a;

    initial begin
        RST = 1'b1;
        EN = 1'b1;
        REQ = 4'b0000;
        LAST = 4'b0000;
        DATA = 32'h0;
        TXFIFO_FULL = 1'b0;
        tick();
        tick();
        look();
        chk("rst_gnt", 32'(GNT), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        chk("rst_wr", 32'(WR_TX), 32'h0);
        chk("rst_irq", 32'(TIMEOUT_IRQ), 32'h0);
        tick();
        RST = 1'b0;

        // Three-byte message from requester 0
        REQ = 4'b0001;
        DATA = 32'h69;
        look();
        chk("s1_idle", 32'(GNT), 32'h0);
        tick();
        look();
        chk("s1_gnt", 32'(GNT), 32'h1);
        chk("s1_wr", 32'(WR_TX), 32'h1);
        chk("s1_b0", 32'(WRDATA), 32'h69);
        tick();
        DATA = 32'h96;
        look();
        chk("s1_b1", 32'(WRDATA), 32'h96);
        tick();
        DATA = 32'h13;
        LAST = 4'b0001;
        look();
        chk("s1_b2", 32'(WRDATA), 32'h13);
        chk("s1_ack", 32'(ACK), 32'h1);
        tick();
        REQ = 4'b0000;
        LAST = 4'b0000;
        DATA = 32'h0;
        look();
        chk("s1_end_gnt", 32'(GNT), 32'h0);
        chk("s1_end_busy", 32'(BUSY), 32'h0);

        RST = 1'b1;
        tick();
        RST = 1'b0;

        // All four request single-byte messages at once
        REQ = 4'hF;
        LAST = 4'hF;
        DATA = 32'h44332211;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            look();
            if (WR_TX && n < 8) begin
                wcyc[n] = c;
                wdat[n] = WRDATA;
                wg[n] = GNT;
                n++;
            end
            a = ACK;
            tick();
            REQ = REQ & ~a;
        end
        chk("s2_writes", 32'(n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("s2_order", 32'(wg[i]), 32'(1 << i));
            chk("s2_byte", 32'(wdat[i]), 32'(8'h11 * (i + 1)));
            chk("s2_gap", 32'(wcyc[i]), 32'(2 * i + 1));
        end
        REQ = 4'b0000;
        LAST = 4'b0000;
        DATA = 32'h0;

        // Requester 2 stalled by a full FIFO
        REQ = 4'b0100;
        DATA = 32'h00240000;
        look();
        tick();
        look();
        chk("s3_gnt", 32'(GNT), 32'h4);
        chk("s3_b0", 32'(WRDATA), 32'h24);
        tick();
        DATA = 32'h00570000;
        TXFIFO_FULL = 1'b1;
        for (int i = 0; i < 5; i++) begin
            look();
            chk("s3_stall_wr", 32'(WR_TX), 32'h0);
            chk("s3_stall_gnt", 32'(GNT), 32'h4);
            tick();
        end
        TXFIFO_FULL = 1'b0;
        LAST = 4'b0100;
        look();
        chk("s3_b1_wr", 32'(WR_TX), 32'h1);
        chk("s3_b1", 32'(WRDATA), 32'h57);
        tick();
        REQ = 4'b0000;
        LAST = 4'b0000;
        DATA = 32'h0;
        look();
        chk("s3_end", 32'(GNT), 32'h0);

        // Reset abandons requester 2's message; pointer returns to 0
        REQ = 4'b0100;
        DATA = 32'h005A0000;
        look();
        tick();
        look();
        chk("s5_gnt", 32'(GNT), 32'h4);
        chk("s5_b0", 32'(WRDATA), 32'h5A);
        tick();
        RST = 1'b1;
        REQ = 4'b1101;
        DATA = 32'hD35B00C0;
        look();
        chk("s5_rst_wr", 32'(WR_TX), 32'h0);
        tick();
        RST = 1'b0;
        REQ = 4'b1001;
        look();
        chk("s5_after_gnt", 32'(GNT), 32'h0);
        chk("s5_after_busy", 32'(BUSY), 32'h0);
        chk("s5_after_wr", 32'(WR_TX), 32'h0);
        tick();
        LAST = 4'b1001;
        look();
        chk("s5_fresh", 32'(GNT), 32'h1);
        chk("s5_fresh_b", 32'(WRDATA), 32'hC0);
        tick();
        REQ = 4'b1000;
        look();
        chk("s5_gap", 32'(GNT), 32'h0);
        tick();
        look();
        chk("s5_g3", 32'(GNT), 32'h8);
        chk("s5_g3_b", 32'(WRDATA), 32'hD3);
        tick();
        REQ = 4'b0000;
        LAST = 4'b0000;
        DATA = 32'h0;

        // Disabled arbiter issues no grant
        EN = 1'b0;
        REQ = 4'b0010;
        DATA = 32'h0000A100;
        look();
        chk("en0_gnt_a", 32'(GNT), 32'h0);
        tick();
        look();
        chk("en0_gnt_b", 32'(GNT), 32'h0);
        tick();
        EN = 1'b1;

        // Requester 3 arrives while requester 1 owns the channel
        look();
        tick();
        look();
        chk("s4_gnt", 32'(GNT), 32'h2);
        chk("s4_b0", 32'(WRDATA), 32'hA1);
        tick();
        REQ = 4'b1010;
        DATA = 32'hE300A200;
        look();
        chk("s4_noack3", 32'(ACK), 32'h2);
        chk("s4_b1", 32'(WRDATA), 32'hA2);
        tick();
        EN = 1'b0;
        DATA = 32'hE300A300;
        look();
        chk("s4_en0_wr", 32'(WR_TX), 32'h0);
        chk("s4_en0_gnt", 32'(GNT), 32'h2);
        tick();
        EN = 1'b1;
        LAST = 4'b1010;
        look();
        chk("s4_last_ack", 32'(ACK), 32'h2);
        chk("s4_b2", 32'(WRDATA), 32'hA3);
        tick();
        REQ = 4'b1000;
        look();
        chk("s4_gap", 32'(GNT), 32'h0);
        tick();
        look();
        chk("s4_g3", 32'(GNT), 32'h8);
        chk("s4_g3_b", 32'(WRDATA), 32'hE3);
        tick();
        REQ = 4'b0000;
        LAST = 4'b0000;
        DATA = 32'h0;

        // Owner 0 goes quiet after one byte while requester 1 waits
        REQ = 4'b0001;
        DATA = 32'h000000B0;
        look();
        tick();
        look();
        chk("s6_gnt", 32'(GNT), 32'h1);
        chk("s6_b0", 32'(WRDATA), 32'hB0);
        tick();
        REQ = 4'b0010;
        DATA = 32'h0000B100;
        LAST = 4'b0010;
`ifdef UART_ARB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            look();
            chk("s6_hold", 32'(GNT), 32'h1);
            chk("s6_noirq", 32'(TIMEOUT_IRQ), 32'h0);
            tick();
        end
        look();
        chk("s6_irq", 32'(TIMEOUT_IRQ), 32'h1);
        chk("s6_rel_gnt", 32'(GNT), 32'h0);
        chk("s6_rel_busy", 32'(BUSY), 32'h0);
        tick();
        look();
        chk("s6_irq_off", 32'(TIMEOUT_IRQ), 32'h0);
        chk("s6_next", 32'(GNT), 32'h2);
        chk("s6_next_b", 32'(WRDATA), 32'hB1);
        tick();
`else
        for (int i = 0; i < 12; i++) begin
            look();
            chk("s6_hold", 32'(GNT), 32'h1);
            chk("s6_noirq", 32'(TIMEOUT_IRQ), 32'h0);
            chk("s6_noack", 32'(ACK), 32'h0);
            tick();
        end
        REQ = 4'b0011;
        DATA = 32'h0000B1B5;
        LAST = 4'b0011;
        look();
        chk("s6_resume", 32'(GNT), 32'h1);
        chk("s6_resume_b", 32'(WRDATA), 32'hB5);
        tick();
        REQ = 4'b0010;
        look();
        chk("s6_gap", 32'(GNT), 32'h0);
        tick();
        look();
        chk("s6_next", 32'(GNT), 32'h2);
        chk("s6_next_b", 32'(WRDATA), 32'hB1);
        tick();
`endif
        REQ = 4'b0000;
        LAST = 4'b0000;
        DATA = 32'h0;
        look();
        chk("final_idle", 32'(GNT), 32'h0);
        tick();
        tick();
        look();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
